sprite_cmd_encoder: RTL and testbench
=====================================

Name: sprite_cmd_encoder

Overview:
Command-word transmitter for the sprite display pipeline. It holds a software-written staging table of per-child sprite state (visibility, flip, pattern, x, y, shift). At each frame_start it snapshots that table and serialises it into 32-bit display command words aimed at the back buffer, then issues a flush word that swaps buffers. It drives the writedata bus of one sprite display sub-component (for example sub_comp 5, the Goomba display) through a valid/ready arbiter port.

Parameters:
- SUB_COMP_ID, 6'd5: sub_comp field placed in every emitted word.
- CHILD_NUM, 2: number of sprite children; legal range 1..31.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tbl_we  in  1  staging-table write strobe.
- tbl_child  in  5  child index for the write.
- tbl_sel  in  3  field select, same codes as the word type field: 001 attr, 010 x, 011 y, 100 shift.
- tbl_data  in  13  field data, laid out as the word msg field.
- frame_start  in  1  one-cycle pulse at vblank start.
- cmd_ready  in  1  bus arbiter accepts cmd_data this cycle.
- cmd_valid  out  1  cmd_data holds a real command.
- cmd_data  out  32  command word.
- busy  out  1  a frame burst is in progress.
- front_buf  out  1  buffer currently displayed (last flushed).
- overrun_cnt  out  8  saturating count of dropped frame_start pulses.

Behaviour:
- Word format: [31:26]=SUB_COMP_ID, [25:21]=child, [20:17]=info, [16:14]=type, [13]=pp_selc, [12:0]=msg.
- Normal word: info=4'b0001 and pp_selc=~front_buf (the back buffer).
  - attr (type 001): msg = {visible, flip, 6'b0, pattern[4:0]}.
  - x (type 010), y (type 011), shift (type 100): msg = {3'b0, value[9:0]}.
- Flush word: info=4'b1111, child=0, type=0, msg=0, pp_selc=~front_buf.
- When cmd_valid=0, cmd_data must be 32'h0. This is the info=0 no-op; the receiver samples the bus every clock.
- Staging table write:
  - On tbl_we, writes the selected field of child tbl_child.
  - Ignored if tbl_child>=CHILD_NUM or tbl_sel is not in {001,010,011,100}.
  - attr writes store visible=tbl_data[12], flip=tbl_data[11], pattern=tbl_data[4:0].
  - Writes are accepted in every state.
- FSM states: IDLE, SEND, FLUSH.
  - IDLE + frame_start: copy staging to the send table (a same-cycle tbl_we is included in the copy); go to SEND with child=0, field=attr.
  - SEND: presents child c, field f. Order per child is attr, x, y, shift; children go 0..CHILD_NUM-1. On cmd_valid&&cmd_ready, advance. After the last child's shift is accepted, go to FLUSH.
  - FLUSH: present the flush word. On acceptance, toggle front_buf and return to IDLE.
- Latency:
  - frame_start at cycle t gives cmd_valid=1 with the first attr word at t+1.
  - With cmd_ready held at 1, the burst is 4*CHILD_NUM+1 consecutive words, and front_buf toggles on the clock edge after the flush is accepted.
- Handshake:
  - cmd_data is stable while cmd_valid=1 and cmd_ready=0.
  - cmd_valid never drops before acceptance.
  - cmd_ready while cmd_valid=0 is ignored.
- busy is 1 in SEND and FLUSH.
- frame_start while busy:
  - The pulse is dropped and overrun_cnt increments, saturating at 255.
  - The burst in progress is not restarted and the send table is not altered.
- Staging writes during a burst affect only the next frame.
- Reset (async, active-low), effective immediately even mid-burst:
  - FSM goes to IDLE; cmd_valid=0, cmd_data=0, busy=0, front_buf=0, overrun_cnt=0.
  - Staging and send tables clear to all-zero (all children invisible).
  - The first frame after reset therefore targets buffer 1, matching the receiver's reset ping_pong=0.

Test Plan:
1. Reset, write child0 attr=13'h1001, x=100, frame_start, cmd_ready=1 -> words in order: 0x14027001, 0x1402A064, then y and shift for child0 (value 0); then child1's four words; then 0x141E2000; 9 words in total; front_buf 0->1.
2. Write child1 y=50, second frame_start -> the child1 y word is 0x1422C032 (pp_selc=0); flush is 0x141E0000; front_buf 1->0.
3. Hold cmd_ready=0 for 3 cycles on the second word -> cmd_data stays 0x1402A064 and cmd_valid stays 1; the burst completes once cmd_ready=1.
4. frame_start while busy, 300 times -> overrun_cnt=255, burst order unchanged; tbl_we with tbl_child=5 -> no table change.
5. tbl_we child0 x=7 in the same cycle as frame_start in IDLE -> the emitted x word carries msg=7; a write during the burst appears only in the next frame.
6. Assert reset mid-SEND -> cmd_valid=0, cmd_data=0, busy=0, front_buf=0 immediately; the next burst's attr words have visible=0.

Source files
------------

// File: rtl/sprite_cmd_encoder.sv
// Sprite command-word transmitter. Software fills a staging table of
// per-child sprite state; each frame_start snapshots it into a send table
// and streams it out as 32-bit display commands aimed at the back buffer,
// followed by a flush word that swaps buffers.
//
// Handshake: cmd_valid/cmd_data are driven purely from registered state.
// A word is accepted on any clock where cmd_valid && cmd_ready. While
// cmd_valid is high and the word is not accepted, cmd_data holds steady
// and cmd_valid stays high. cmd_ready is ignored while cmd_valid is low,
// and cmd_data is forced to the all-zero no-op whenever cmd_valid is low.
module sprite_cmd_encoder #(
    parameter logic [5:0] SUB_COMP_ID = 6'd5,
    parameter int         CHILD_NUM   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tbl_we,
    input  logic [4:0]  tbl_child,
    input  logic [2:0]  tbl_sel,
    input  logic [12:0] tbl_data,
    input  logic        frame_start,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [31:0] cmd_data,
    output logic        busy,
    output logic        front_buf,
    output logic [7:0]  overrun_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [4:0] LAST_CHILD = 5'(CHILD_NUM - 1);

    state_t     state, state_n;
    logic [4:0] child, child_n;
    logic [1:0] field, field_n;   // 0 attr, 1 x, 2 y, 3 shift
    logic       front_n;
    logic       snap;

    // Staging table (software view) and its next value including this cycle's write
    logic [CHILD_NUM-1:0]       stg_vis, stg_flip, stg_vis_n, stg_flip_n;
    logic [CHILD_NUM-1:0][4:0]  stg_pat, stg_pat_n;
    logic [CHILD_NUM-1:0][9:0]  stg_x, stg_y, stg_sh, stg_x_n, stg_y_n, stg_sh_n;

    // Send table, frozen for the duration of a burst
    logic [CHILD_NUM-1:0]       snd_vis, snd_flip;
    logic [CHILD_NUM-1:0][4:0]  snd_pat;
    logic [CHILD_NUM-1:0][9:0]  snd_x, snd_y, snd_sh;

    // Currently addressed send-table entry
    logic       cur_vis, cur_flip;
    logic [4:0] cur_pat;
    logic [9:0] cur_x, cur_y, cur_sh;
    logic [2:0]  word_type;
    logic [12:0] word_msg;

    // Apply the staging write; out-of-range children and unknown selects fall through
    always_comb begin
        stg_vis_n  = stg_vis;
        stg_flip_n = stg_flip;
        stg_pat_n  = stg_pat;
        stg_x_n    = stg_x;
        stg_y_n    = stg_y;
        stg_sh_n   = stg_sh;
        if (tbl_we) begin
            for (int i = 0; i < CHILD_NUM; i++) begin
                if (tbl_child == 5'(i)) begin
                    case (tbl_sel)
                        3'b001: begin
                            stg_vis_n[i]  = tbl_data[12];
                            stg_flip_n[i] = tbl_data[11];
                            stg_pat_n[i]  = tbl_data[4:0];
                        end
                        3'b010:  stg_x_n[i]  = tbl_data[9:0];
                        3'b011:  stg_y_n[i]  = tbl_data[9:0];
                        3'b100:  stg_sh_n[i] = tbl_data[9:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Snapshot happens only when a frame starts from IDLE; pulses while busy are dropped
    assign snap = (state == IDLE) && frame_start;

    // Staging and send table storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stg_vis  <= '0;
            stg_flip <= '0;
            stg_pat  <= '0;
            stg_x    <= '0;
            stg_y    <= '0;
            stg_sh   <= '0;
            snd_vis  <= '0;
            snd_flip <= '0;
            snd_pat  <= '0;
            snd_x    <= '0;
            snd_y    <= '0;
            snd_sh   <= '0;
        end else begin
            stg_vis  <= stg_vis_n;
            stg_flip <= stg_flip_n;
            stg_pat  <= stg_pat_n;
            stg_x    <= stg_x_n;
            stg_y    <= stg_y_n;
            stg_sh   <= stg_sh_n;
            if (snap) begin
                snd_vis  <= stg_vis_n;
                snd_flip <= stg_flip_n;
                snd_pat  <= stg_pat_n;
                snd_x    <= stg_x_n;
                snd_y    <= stg_y_n;
                snd_sh   <= stg_sh_n;
            end
        end
    end

    // FSM state, burst position and displayed-buffer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            child     <= '0;
            field     <= '0;
            front_buf <= 1'b0;
        end else begin
            state     <= state_n;
            child     <= child_n;
            field     <= field_n;
            front_buf <= front_n;
        end
    end

    // Next-state logic: walk attr,x,y,shift per child, then flush
    always_comb begin
        state_n   = state;
        child_n   = child;
        field_n   = field;
        front_n   = front_buf;
        cmd_valid = (state != IDLE);
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_n = SEND;
                    child_n = '0;
                    field_n = '0;
                end
            end
            SEND: begin
                if (cmd_valid && cmd_ready) begin
                    if (field == 2'd3) begin
                        field_n = '0;
                        if (child == LAST_CHILD) begin
                            state_n = FLUSH;
                            child_n = '0;
                        end else begin
                            child_n = child + 5'd1;
                        end
                    end else begin
                        field_n = field + 2'd1;
                    end
                end
            end
            FLUSH: begin
                if (cmd_valid && cmd_ready) begin
                    state_n = IDLE;
                    front_n = ~front_buf;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Select the send-table entry for the child being presented
    always_comb begin
        cur_vis  = 1'b0;
        cur_flip = 1'b0;
        cur_pat  = '0;
        cur_x    = '0;
        cur_y    = '0;
        cur_sh   = '0;
        for (int i = 0; i < CHILD_NUM; i++) begin
            if (child == 5'(i)) begin
                cur_vis  = snd_vis[i];
                cur_flip = snd_flip[i];
                cur_pat  = snd_pat[i];
                cur_x    = snd_x[i];
                cur_y    = snd_y[i];
                cur_sh   = snd_sh[i];
            end
        end
    end

    // Format the outgoing word; zero is the no-op the receiver ignores
    always_comb begin
        word_type = {1'b0, field} + 3'd1;
        case (field)
            2'd0:    word_msg = {cur_vis, cur_flip, 6'b0, cur_pat};
            2'd1:    word_msg = {3'b0, cur_x};
            2'd2:    word_msg = {3'b0, cur_y};
            default: word_msg = {3'b0, cur_sh};
        endcase
        cmd_data = 32'h0;
        if (state == SEND)
            cmd_data = {SUB_COMP_ID, child, 4'b0001, word_type, ~front_buf, word_msg};
        else if (state == FLUSH)
            cmd_data = {SUB_COMP_ID, 5'd0, 4'b1111, 3'b000, ~front_buf, 13'd0};
    end

    // Count frame_start pulses lost because a burst was still running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            overrun_cnt <= '0;
        else if (frame_start && busy && overrun_cnt != 8'hFF)
            overrun_cnt <= overrun_cnt + 8'd1;
    end

endmodule

// File: tb/tb_sprite_cmd_encoder.sv
// Bench for sprite_cmd_encoder: directed scenarios plus a random phase,
// checked every cycle against a word-list reference model.
module tb_sprite_cmd_encoder;

    localparam int CHILD_NUM = 2;
    localparam int SUB_ID    = 5;

    logic        clk;
    logic        reset;
    logic        tbl_we;
    logic [4:0]  tbl_child;
    logic [2:0]  tbl_sel;
    logic [12:0] tbl_data;
    logic        frame_start;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic        busy;
    logic        front_buf;
    logic [7:0]  overrun_cnt;

    int n_vec;
    int n_err;

    // Reference model: staging table, pending burst words, buffer and overrun state
    int m_vis [CHILD_NUM];
    int m_flip[CHILD_NUM];
    int m_pat [CHILD_NUM];
    int m_x   [CHILD_NUM];
    int m_y   [CHILD_NUM];
    int m_sh  [CHILD_NUM];
    int m_front;
    int m_over;
    logic [31:0] exp_q[$];

    sprite_cmd_encoder #(.SUB_COMP_ID(6'd5), .CHILD_NUM(CHILD_NUM)) dut (
        .clk(clk),
        .reset(reset),
        .tbl_we(tbl_we),
        .tbl_child(tbl_child),
        .tbl_sel(tbl_sel),
        .tbl_data(tbl_data),
        .frame_start(frame_start),
        .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid),
        .cmd_data(cmd_data),
        .busy(busy),
        .front_buf(front_buf),
        .overrun_cnt(overrun_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endfunction

    function automatic logic [31:0] mk_word(input int child, input int info, input int typ,
                                            input int pp, input int msg);
        int unsigned w;
        w = SUB_ID * (1 << 26) + child * (1 << 21) + info * (1 << 17)
            + typ * (1 << 14) + pp * (1 << 13) + msg;
        return w;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < CHILD_NUM; i++) begin
            m_vis[i] = 0; m_flip[i] = 0; m_pat[i] = 0;
            m_x[i] = 0;   m_y[i] = 0;    m_sh[i] = 0;
        end
        m_front = 0;
        m_over  = 0;
        exp_q.delete();
    endfunction

    function automatic void model_write(input int child, input int sel, input int data);
        if (child < CHILD_NUM) begin
            case (sel)
                1: begin
                    m_vis[child]  = (data >> 12) & 1;
                    m_flip[child] = (data >> 11) & 1;
                    m_pat[child]  = data & 31;
                end
                2: m_x[child]  = data & 1023;
                3: m_y[child]  = data & 1023;
                4: m_sh[child] = data & 1023;
                default: ;
            endcase
        end
    endfunction

    function automatic void model_snapshot();
        int pp;
        pp = (m_front == 0) ? 1 : 0;
        for (int c = 0; c < CHILD_NUM; c++) begin
            exp_q.push_back(mk_word(c, 1, 1, pp, m_vis[c] * 4096 + m_flip[c] * 2048 + m_pat[c]));
            exp_q.push_back(mk_word(c, 1, 2, pp, m_x[c]));
            exp_q.push_back(mk_word(c, 1, 3, pp, m_y[c]));
            exp_q.push_back(mk_word(c, 1, 4, pp, m_sh[c]));
        end
        exp_q.push_back(mk_word(0, 15, 0, pp, 0));
    endfunction

    // Model update on each rising edge from the inputs the bench drives
    always @(posedge clk) begin
        bit was_busy;
        logic [31:0] dropped;
        if (reset) begin
            was_busy = (exp_q.size() != 0);
            if (was_busy && cmd_ready) begin
                dropped = exp_q.pop_front();
                if (exp_q.size() == 0) m_front = 1 - m_front;
            end
            if (tbl_we) model_write(int'(tbl_child), int'(tbl_sel), int'(tbl_data));
            if (frame_start) begin
                if (was_busy) begin
                    if (m_over < 255) m_over++;
                end else begin
                    model_snapshot();
                end
            end
        end
    end

    // Scoreboard: compare every output against the model on the falling edge
    always @(negedge clk) begin
        logic [31:0] exp_data;
        exp_data = (exp_q.size() != 0) ? exp_q[0] : 32'h0;
        check("cmd_valid", {31'b0, cmd_valid}, {31'b0, exp_q.size() != 0});
        check("cmd_data", cmd_data, exp_data);
        check("busy", {31'b0, busy}, {31'b0, exp_q.size() != 0});
        check("front_buf", {31'b0, front_buf}, 32'(m_front));
        check("overrun_cnt", {24'b0, overrun_cnt}, 32'(m_over));
    end

    // Driver tasks: inputs change just after the falling edge
    task automatic step();
        @(negedge clk);
    endtask

    task automatic tbl_write(input int child, input int sel, input int data);
        tbl_we    = 1'b1;
        tbl_child = 5'(child);
        tbl_sel   = 3'(sel);
        tbl_data  = 13'(data);
        step();
        tbl_we    = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", {31'b0, busy}, 32'h0);
    endtask

    task automatic apply_reset();
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check("rst_cmd_valid", {31'b0, cmd_valid}, 32'h0);
        check("rst_cmd_data", cmd_data, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_front_buf", {31'b0, front_buf}, 32'h0);
        check("rst_overrun", {24'b0, overrun_cnt}, 32'h0);
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset       = 1'b0;
        tbl_we      = 1'b0;
        tbl_child   = '0;
        tbl_sel     = '0;
        tbl_data    = '0;
        frame_start = 1'b0;
        cmd_ready   = 1'b0;
        model_clear();
        step();
        apply_reset();
        step();

        // 1: first frame after reset targets buffer 1
        tbl_write(0, 1, 13'h1001);
        tbl_write(0, 2, 100);
        cmd_ready = 1'b1;
        pulse_frame();
        check("t1_first_attr", cmd_data, 32'h14027001);
        step();
        check("t1_first_x", cmd_data, 32'h1402A064);
        wait_idle(50);
        check("t1_front_buf", {31'b0, front_buf}, 32'h1);

        // 2: second frame targets buffer 0
        tbl_write(1, 3, 50);
        pulse_frame();
        repeat (6) step();
        check("t2_child1_y", cmd_data, 32'h1422C032);
        repeat (2) step();
        check("t2_flush", cmd_data, 32'h141E0000);
        wait_idle(50);
        check("t2_front_buf", {31'b0, front_buf}, 32'h0);

        // 3: stall on the second word
        pulse_frame();
        step();
        cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_stall_data", cmd_data, 32'h1402A064);
            check("t3_stall_valid", {31'b0, cmd_valid}, 32'h1);
        end
        cmd_ready = 1'b1;
        wait_idle(50);

        // 4: frame_start hammered during slow bursts; out-of-range write ignored
        for (int i = 0; i < 300; i++) begin
            frame_start = 1'b1;
            cmd_ready   = ($urandom_range(0, 9) == 0);
            step();
        end
        frame_start = 1'b0;
        cmd_ready   = 1'b1;
        wait_idle(100);
        check("t4_overrun_sat", {24'b0, overrun_cnt}, 32'd255);
        tbl_write(5, 1, 13'h1FFF);
        tbl_write(5, 2, 13'h3FF);
        pulse_frame();
        wait_idle(50);

        // 5: same-cycle write with frame_start is captured; mid-burst write waits
        tbl_we = 1'b1; tbl_child = 5'd0; tbl_sel = 3'b010; tbl_data = 13'd7;
        frame_start = 1'b1;
        step();
        tbl_we = 1'b0;
        frame_start = 1'b0;
        step();
        check("t5_x_msg", {19'b0, cmd_data[12:0]}, 32'd7);
        tbl_write(0, 2, 9);
        wait_idle(50);
        pulse_frame();
        step();
        check("t5_next_x_msg", {19'b0, cmd_data[12:0]}, 32'd9);
        wait_idle(50);

        // 6: reset in the middle of a burst
        pulse_frame();
        step();
        apply_reset();
        pulse_frame();
        check("t6_attr_invisible", {31'b0, cmd_data[12]}, 32'h0);
        check("t6_pp_selc", {31'b0, cmd_data[13]}, 32'h1);
        wait_idle(50);

        // Random phase
        for (int i = 0; i < 600; i++) begin
            tbl_we      = ($urandom_range(0, 3) == 0);
            tbl_child   = 5'($urandom_range(0, 3));
            tbl_sel     = 3'($urandom_range(0, 7));
            tbl_data    = 13'($urandom);
            frame_start = ($urandom_range(0, 19) == 0);
            cmd_ready   = ($urandom_range(0, 1) == 1);
            step();
        end
        tbl_we      = 1'b0;
        frame_start = 1'b0;
        cmd_ready   = 1'b1;
        wait_idle(100);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
